// File: rtl/noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_output_arbiter
//
// Wormhole arbiter for one NOC router output port. Up to N_IN input-port
// buffers compete for the link. Head and single flits are arbitrated
// round-robin; once a head flit wins, the link is locked to that input until
// its tail flit has been forwarded, so packets never interleave. Nothing moves
// while the output buffer reports full.
//
// Flit type lives in the two MSBs of each flit:
//   2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail at once)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   req_i        per-input request, bit j = input j has a flit for this port
//   data_i       flattened flits, input j at [W*j +: W]
//   full_i       output buffer full, blocks every transfer
//   grant_o      one-hot pop strobe back to the winning input
//   data_o       forwarded flit, zero when nothing is transferred
//   port_en_o    push strobe to the output buffer
//   owner_o      locked input index, meaningful only while busy_o
//   busy_o       high while locked in the middle of a packet
//   pkt_cnt_o    completed-packet counter, wraps
//   proto_err_o  sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module noc_output_arbiter #(
  parameter int N_IN = 5,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   req_i,
  input  logic [N_IN*W-1:0] data_i,
  input  logic              full_i,
  output logic [N_IN-1:0]   grant_o,
  output logic [W-1:0]      data_o,
  output logic              port_en_o,
  output logic [2:0]        owner_o,
  output logic              busy_o,
  output logic [15:0]       pkt_cnt_o,
  output logic              proto_err_o
);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  owner, owner_nxt;
  logic [2:0]  rr_ptr, rr_ptr_nxt;
  logic [15:0] pkt_cnt, pkt_cnt_nxt;
  logic        proto_err, proto_err_nxt;

  logic [W-1:0]    flit  [N_IN];
  logic [1:0]      ftype [N_IN];
  logic [N_IN-1:0] head_cand;
  logic [N_IN-1:0] bad_req;
  logic [3:0]      pick;

  logic            vld_p0;
  logic [2:0]      sel_p0;

  // Round-robin search: first set bit of cand starting at ptr and wrapping.
  // Offsets are scanned from the far end so the nearest candidate is the
  // last (and therefore winning) assignment. Result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [N_IN-1:0] cand,
                                         input logic [2:0]      ptr);
    logic [3:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(N_IN)) begin
        idx = idx - 4'(N_IN);
      end
      if (cand[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

  // Next pointer value after a grant to input x, wrapping at N_IN.
  function automatic logic [2:0] rr_inc(input logic [2:0] x);
    logic [2:0] r;
    if (x == 3'(N_IN - 1)) begin
      r = 3'd0;
    end else begin
      r = x + 3'd1;
    end
    return r;
  endfunction

  // Unpack per-input flits and classify them. A requesting body or tail flit
  // can never start a packet, so in IDLE it is flagged instead of considered.
  for (genvar j = 0; j < N_IN; j++) begin : g_in
    assign flit[j]      = data_i[W*j +: W];
    assign ftype[j]     = flit[j][W-1 -: 2];
    assign head_cand[j] = req_i[j] & ((ftype[j] == FT_HEAD) | (ftype[j] == FT_SINGLE));
    assign bad_req[j]   = req_i[j] & ((ftype[j] == FT_BODY) | (ftype[j] == FT_TAIL));
  end

  assign pick = rr_pick(head_cand, rr_ptr);

  // ---- stage p0: arbitration decision and next state (combinational) ----
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    pkt_cnt_nxt   = pkt_cnt;
    proto_err_nxt = proto_err;
    vld_p0        = 1'b0;
    sel_p0        = owner;

    unique case (state)
      IDLE: begin
        // full_i freezes everything, including the error flag.
        if (!full_i) begin
          if (|bad_req) begin
            proto_err_nxt = 1'b1;
          end
          if (pick[3]) begin
            vld_p0     = 1'b1;
            sel_p0     = pick[2:0];
            rr_ptr_nxt = rr_inc(pick[2:0]);
            if (ftype[pick[2:0]] == FT_HEAD) begin
              state_nxt = LOCKED;
              owner_nxt = pick[2:0];
            end else begin
              pkt_cnt_nxt = pkt_cnt + 16'd1;
            end
          end
        end
      end

      LOCKED: begin
        // Only the owner is looked at; the pointer holds so the other inputs
        // keep their place in the rotation for the next packet.
        if (!full_i && req_i[owner]) begin
          vld_p0 = 1'b1;
          sel_p0 = owner;
          unique case (ftype[owner])
            FT_TAIL: begin
              state_nxt   = IDLE;
              pkt_cnt_nxt = pkt_cnt + 16'd1;
            end
            // A new packet start inside a packet is passed through as payload
            // but recorded as a protocol violation.
            FT_HEAD, FT_SINGLE: begin
              proto_err_nxt = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
      end
    endcase
  end

  // Transfer outputs are driven straight from the p0 decision so a flit is
  // pushed in the same cycle it is presented.
  always_comb begin
    grant_o   = '0;
    data_o    = '0;
    port_en_o = vld_p0;
    if (vld_p0) begin
      grant_o[sel_p0] = 1'b1;
      data_o          = flit[sel_p0];
    end
  end

  // ---- stage p1: registered arbitration state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 3'd0;
      rr_ptr    <= 3'd0;
      pkt_cnt   <= 16'd0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      pkt_cnt   <= pkt_cnt_nxt;
      proto_err <= proto_err_nxt;
    end
  end

  assign busy_o      = (state == LOCKED);
  assign owner_o     = owner;
  assign pkt_cnt_o   = pkt_cnt;
  assign proto_err_o = proto_err;

endmodule

// File: tb/tb_noc_output_arbiter.sv
module tb_noc_output_arbiter;

  localparam int N  = 5;
  localparam int WD = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [N*WD-1:0] din = '0;
  logic          full  = 1'b0;

  logic [N-1:0]  grant_o;
  logic [WD-1:0] data_o;
  logic          port_en_o;
  logic [2:0]    owner_o;
  logic          busy_o;
  logic [15:0]   pkt_cnt_o;
  logic          proto_err_o;

  noc_output_arbiter #(.N_IN(N), .W(WD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .data_i     (din),
    .full_i     (full),
    .grant_o    (grant_o),
    .data_o     (data_o),
    .port_en_o  (port_en_o),
    .owner_o    (owner_o),
    .busy_o     (busy_o),
    .pkt_cnt_o  (pkt_cnt_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what a packet-level observer expects.
  bit m_lock;
  int m_own;
  int m_rr;
  int m_cnt;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ftype(input logic [N*WD-1:0] d, input int j);
    return d[WD*j+WD-2 +: 2];
  endfunction

  function automatic logic [WD-1:0] fdat(input logic [N*WD-1:0] d, input int j);
    return d[WD*j +: WD];
  endfunction

  // Which input the link should serve this cycle (-1 = none).
  function automatic int model_win(input logic [N-1:0] r, input logic [N*WD-1:0] d,
                                   input logic f);
    int w;
    int j;
    logic [1:0] t;
    w = -1;
    if (f) return -1;
    if (m_lock) return r[m_own] ? m_own : -1;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      t = ftype(d, j);
      if (w < 0 && r[j] && (t == 2'b01 || t == 2'b11)) w = j;
    end
    return w;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic [N*WD-1:0] d,
                              input logic f, input int w);
    logic [1:0] t;
    if (f) return;
    if (!m_lock) begin
      for (int j = 0; j < N; j++) begin
        t = ftype(d, j);
        if (r[j] && (t == 2'b00 || t == 2'b10)) m_err = 1'b1;
      end
      if (w >= 0) begin
        m_rr = (w + 1) % N;
        t = ftype(d, w);
        if (t == 2'b01) begin
          m_lock = 1'b1;
          m_own  = w;
        end else begin
          m_cnt = (m_cnt + 1) % 65536;
        end
      end
    end else if (w >= 0) begin
      t = ftype(d, w);
      if (t == 2'b10) begin
        m_lock = 1'b0;
        m_cnt  = (m_cnt + 1) % 65536;
      end else if (t == 2'b01 || t == 2'b11) begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_cycle(input string tag, input int w, input logic [N*WD-1:0] d);
    logic [N-1:0]  eg;
    logic [WD-1:0] ed;
    eg = '0;
    ed = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ed = fdat(d, w);
    end
    chk($sformatf("%s grant", tag), grant_o, eg);
    chk($sformatf("%s port_en", tag), port_en_o, (w >= 0));
    chk($sformatf("%s data", tag), data_o, ed);
    chk($sformatf("%s busy", tag), busy_o, m_lock);
    if (m_lock) chk($sformatf("%s owner", tag), owner_o, m_own);
    chk($sformatf("%s pkt_cnt", tag), pkt_cnt_o, m_cnt);
    chk($sformatf("%s proto_err", tag), proto_err_o, m_err);
  endtask

  // Drive inputs just after a rising edge, then wait to the falling edge to sample.
  task automatic drive(input logic [N-1:0] r, input logic [N*WD-1:0] d, input logic f);
    req  = r;
    din  = d;
    full = f;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    full  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_lock = 1'b0;
    m_own  = 0;
    m_rr   = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  typedef struct packed {
    logic [N-1:0]    req;
    logic [N*WD-1:0] din;
    logic            full;
    logic [N-1:0]    grant;
    logic            en;
    logic [WD-1:0]   dout;
    logic            busy;
    logic [2:0]      own;
    logic [15:0]     cnt;
    logic            err;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] r, input logic [N*WD-1:0] d, input logic f,
                              input logic [N-1:0] g, input logic e, input logic [WD-1:0] o,
                              input logic b, input logic [2:0] ow, input logic [15:0] c,
                              input logic er);
    vec_t v;
    v.req = r; v.din = d; v.full = f; v.grant = g; v.en = e; v.dout = o;
    v.busy = b; v.own = ow; v.cnt = c; v.err = er;
    return v;
  endfunction

  function automatic logic [N*WD-1:0] wl(input logic [WD-1:0] d1);
    return {16'h0000, 16'h4033, 16'h0000, d1, 16'h0000};
  endfunction

  // Well-formed packet sources for the first random phase.
  int            src_len [N];
  int            src_pos [N];
  logic [WD-1:0] src_fl  [N];

  function automatic logic [WD-1:0] gen_flit(input int p, input int l);
    logic [1:0] t;
    if (l == 1)          t = 2'b11;
    else if (p == 0)     t = 2'b01;
    else if (p == l - 1) t = 2'b10;
    else                 t = 2'b00;
    return {t, 14'($urandom)};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [22];
    logic [N*WD-1:0] singles;
    logic [N-1:0]    r;
    logic [N*WD-1:0] d;
    logic            f;
    int              w;

    singles = {16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000};
    tbl[0]  = mk(5'b00000, '0, 0, 5'b00000, 0, 16'h0000, 0, 3'd0, 16'd0, 0);
    tbl[1]  = mk(5'b00100, {16'h0, 16'h0, 16'hC0AB, 16'h0, 16'h0}, 0,
                 5'b00100, 1, 16'hC0AB, 0, 3'd0, 16'd0, 0);
    tbl[2]  = mk(5'b00000, '0, 0, 5'b00000, 0, 16'h0000, 0, 3'd0, 16'd1, 0);
    tbl[3]  = mk(5'b11111, singles, 0, 5'b01000, 1, 16'hC003, 0, 3'd0, 16'd1, 0);
    tbl[4]  = mk(5'b11111, singles, 0, 5'b10000, 1, 16'hC004, 0, 3'd0, 16'd2, 0);
    tbl[5]  = mk(5'b11111, singles, 0, 5'b00001, 1, 16'hC000, 0, 3'd0, 16'd3, 0);
    tbl[6]  = mk(5'b11111, singles, 0, 5'b00010, 1, 16'hC001, 0, 3'd0, 16'd4, 0);
    tbl[7]  = mk(5'b11111, singles, 0, 5'b00100, 1, 16'hC002, 0, 3'd0, 16'd5, 0);
    tbl[8]  = mk(5'b11111, singles, 0, 5'b01000, 1, 16'hC003, 0, 3'd0, 16'd6, 0);
    tbl[9]  = mk(5'b01010, wl(16'h4011), 0, 5'b00010, 1, 16'h4011, 0, 3'd0, 16'd7, 0);
    tbl[10] = mk(5'b01010, wl(16'h0012), 0, 5'b00010, 1, 16'h0012, 1, 3'd1, 16'd7, 0);
    tbl[11] = mk(5'b01010, wl(16'h0013), 1, 5'b00000, 0, 16'h0000, 1, 3'd1, 16'd7, 0);
    tbl[12] = mk(5'b01010, wl(16'h0013), 1, 5'b00000, 0, 16'h0000, 1, 3'd1, 16'd7, 0);
    tbl[13] = mk(5'b01010, wl(16'h0013), 1, 5'b00000, 0, 16'h0000, 1, 3'd1, 16'd7, 0);
    tbl[14] = mk(5'b01010, wl(16'h0013), 0, 5'b00010, 1, 16'h0013, 1, 3'd1, 16'd7, 0);
    tbl[15] = mk(5'b01010, wl(16'h8014), 0, 5'b00010, 1, 16'h8014, 1, 3'd1, 16'd7, 0);
    tbl[16] = mk(5'b01000, {16'h0, 16'h4033, 16'h0, 16'h0, 16'h0}, 0,
                 5'b01000, 1, 16'h4033, 0, 3'd0, 16'd8, 0);
    tbl[17] = mk(5'b01000, {16'h0, 16'h8034, 16'h0, 16'h0, 16'h0}, 0,
                 5'b01000, 1, 16'h8034, 1, 3'd3, 16'd8, 0);
    tbl[18] = mk(5'b00000, '0, 0, 5'b00000, 0, 16'h0000, 0, 3'd0, 16'd9, 0);
    tbl[19] = mk(5'b00001, {64'h0, 16'hC0FF}, 1, 5'b00000, 0, 16'h0000, 0, 3'd0, 16'd9, 0);
    tbl[20] = mk(5'b00001, {64'h0, 16'hC0FF}, 0, 5'b00001, 1, 16'hC0FF, 0, 3'd0, 16'd9, 0);
    tbl[21] = mk(5'b00000, '0, 0, 5'b00000, 0, 16'h0000, 0, 3'd0, 16'd10, 0);

    do_reset();

    // Directed vectors: single flit, rotation, wormhole lock with a stall.
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].req, tbl[i].din, tbl[i].full);
      chk($sformatf("row%0d grant", i), grant_o, tbl[i].grant);
      chk($sformatf("row%0d port_en", i), port_en_o, tbl[i].en);
      chk($sformatf("row%0d data", i), data_o, tbl[i].dout);
      chk($sformatf("row%0d busy", i), busy_o, tbl[i].busy);
      if (tbl[i].busy) chk($sformatf("row%0d owner", i), owner_o, tbl[i].own);
      chk($sformatf("row%0d pkt_cnt", i), pkt_cnt_o, tbl[i].cnt);
      chk($sformatf("row%0d proto_err", i), proto_err_o, tbl[i].err);
      tick();
    end

    // Body flit while idle: never granted, error is sticky.
    drive(5'b00001, {64'h0, 16'h0001}, 0);
    chk("perr grant", grant_o, 5'b00000);
    chk("perr port_en", port_en_o, 1'b0);
    chk("perr before edge", proto_err_o, 1'b0);
    tick();
    drive(5'b00001, {64'h0, 16'h0001}, 0);
    chk("perr set", proto_err_o, 1'b1);
    chk("perr still no grant", grant_o, 5'b00000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, 0);
      chk($sformatf("perr sticky%0d", i), proto_err_o, 1'b1);
      tick();
    end

    // Head inside a packet is forwarded as payload and keeps the lock.
    drive(5'b10000, {16'h4044, 64'h0}, 0);
    chk("lockerr head grant", grant_o, 5'b10000);
    tick();
    drive(5'b10000, {16'hC045, 64'h0}, 0);
    chk("lockerr single grant", grant_o, 5'b10000);
    chk("lockerr single data", data_o, 16'hC045);
    chk("lockerr busy", busy_o, 1'b1);
    tick();
    drive(5'b10000, {16'h8046, 64'h0}, 0);
    chk("lockerr still busy", busy_o, 1'b1);
    chk("lockerr tail grant", grant_o, 5'b10000);
    tick();
    drive('0, '0, 0);
    chk("lockerr unlocked", busy_o, 1'b0);
    chk("lockerr pkt_cnt", pkt_cnt_o, 16'd11);
    tick();

    // Asynchronous reset in the middle of a packet.
    drive(5'b00100, {32'h0, 16'h4022, 32'h0}, 0);
    chk("areset head grant", grant_o, 5'b00100);
    tick();
    req  = 5'b00100;
    din  = {32'h0, 16'h0022, 32'h0};
    full = 1'b0;
    #1;
    chk("areset locked grant", grant_o, 5'b00100);
    chk("areset locked busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("areset busy", busy_o, 1'b0);
    chk("areset grant", grant_o, 5'b00000);
    chk("areset port_en", port_en_o, 1'b0);
    chk("areset pkt_cnt", pkt_cnt_o, 16'd0);
    chk("areset proto_err", proto_err_o, 1'b0);
    chk("areset owner", owner_o, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("areset leftover body err", proto_err_o, 1'b1);
    chk("areset leftover busy", busy_o, 1'b0);
    @(negedge clk);
    chk("areset leftover grant", grant_o, 5'b00000);
    tick();

    // Random well-formed traffic with backpressure and bubbles.
    do_reset();
    for (int j = 0; j < N; j++) begin
      src_len[j] = $urandom_range(1, 4);
      src_pos[j] = 0;
      src_fl[j]  = gen_flit(0, src_len[j]);
    end
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++) begin
        r[j] = ($urandom_range(0, 9) < 7);
        d[WD*j +: WD] = src_fl[j];
      end
      f = ($urandom_range(0, 4) == 0);
      drive(r, d, f);
      w = model_win(r, d, f);
      check_cycle($sformatf("wf%0d", c), w, d);
      model_update(r, d, f, w);
      if (w >= 0) begin
        src_pos[w]++;
        if (src_pos[w] == src_len[w]) begin
          src_len[w] = $urandom_range(1, 4);
          src_pos[w] = 0;
        end
        src_fl[w] = gen_flit(src_pos[w], src_len[w]);
      end
      tick();
    end

    // Random arbitrary flits, protocol errors included.
    do_reset();
    for (int c = 0; c < 200; c++) begin
      r = 5'($urandom);
      d = 80'({$urandom, $urandom, $urandom});
      f = ($urandom_range(0, 3) == 0);
      drive(r, d, f);
      w = model_win(r, d, f);
      check_cycle($sformatf("rnd%0d", c), w, d);
      model_update(r, d, f, w);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
